// File: rtl/mips_multicycle_ctrl.sv
// Moore main controller for the multi-cycle MIPS datapath: sequences each
// instruction through its cycles and drives datapath enables, mux selects and ALU code.
module mips_multicycle_ctrl #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsrc;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore output table; illegal encodings decode to all-zero controls.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_r;
  state_t next_s;
  ctrl_t  ctrl_r;
  logic   legal_s;

  assign legal_s = (state_r < 4'd12);

  // Next-state selection from the current state and the latched opcode.
  always_comb begin
    next_s = FETCH;
    case (state_r)
      FETCH:  next_s = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_s = MEMADR;
          OP_RTYPE:     next_s = EXECUTE;
          OP_BEQ:       next_s = BRANCH;
          OP_ADDI:      next_s = ENABLE_ADDI ? ADDIEX : FETCH;
          OP_J:         next_s = ENABLE_JUMP ? JUMP : FETCH;
          default:      next_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW) begin
          next_s = MEMRD;
        end else if (op == OP_SW) begin
          next_s = MEMWR;
        end else begin
          next_s = FETCH;
        end
      end
      MEMRD:   next_s = MEMWB;
      EXECUTE: next_s = ALUWB;
      ADDIEX:  next_s = ADDIWB;
      default: next_s = FETCH;
    endcase
  end

  // State register with the controls of the entered state registered alongside it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= FETCH;
      ctrl_r  <= decode_ctrl(FETCH);
    end else begin
      state_r <= next_s;
      ctrl_r  <= decode_ctrl(next_s);
    end
  end

  // ALU function code from aluop, with funct decode for R-type execute.
  always_comb begin
    alucontrol = 3'b010;
    case (ctrl_r.aluop)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Write enables are suppressed during reset and in any corrupted state.
  assign pcen     = reset_n & legal_s & (ctrl_r.pcwrite | (ctrl_r.branch & zero));
  assign irwrite  = reset_n & legal_s & ctrl_r.irwrite;
  assign memwrite = reset_n & legal_s & ctrl_r.memwrite;
  assign regwrite = reset_n & legal_s & ctrl_r.regwrite;
  assign iord     = ctrl_r.iord;
  assign alusrca  = ctrl_r.alusrca;
  assign alusrcb  = ctrl_r.alusrcb;
  assign regdst   = ctrl_r.regdst;
  assign memtoreg = ctrl_r.memtoreg;
  assign pcsrc    = ctrl_r.pcsrc;
  assign state    = state_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: full-feature instance plus one with
// addi and j disabled, sharing the same stimulus.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;

  logic       pcen, irwrite, memwrite, regwrite, iord, alusrca, regdst, memtoreg;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  logic       pcen2, irwrite2, memwrite2, regwrite2, iord2, alusrca2, regdst2, memtoreg2;
  logic [1:0] alusrcb2, pcsrc2;
  logic [2:0] alucontrol2;
  logic [3:0] state2;

  int nvec = 0;
  int nerr = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .regdst(regdst),
    .memtoreg(memtoreg), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  mips_multicycle_ctrl #(.ENABLE_ADDI(1'b0), .ENABLE_JUMP(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen2), .irwrite(irwrite2), .memwrite(memwrite2), .regwrite(regwrite2),
    .iord(iord2), .alusrca(alusrca2), .alusrcb(alusrcb2), .regdst(regdst2),
    .memtoreg(memtoreg2), .pcsrc(pcsrc2), .alucontrol(alucontrol2), .state(state2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_noen(input string tag);
    chk({tag, " pcen"}, 8'(pcen), 8'd0);
    chk({tag, " irwrite"}, 8'(irwrite), 8'd0);
    chk({tag, " memwrite"}, 8'(memwrite), 8'd0);
    chk({tag, " regwrite"}, 8'(regwrite), 8'd0);
  endtask

  logic [5:0] fn_tab [6];
  logic [2:0] alu_tab [6];

  initial begin
    fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    alu_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

    // Reset held for three cycles
    #3 reset_n = 1'b0;
    #1;
    chk("rst state", 8'(state), 8'd0);
    chk_noen("rst");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst hold state", 8'(state), 8'd0);
      chk_noen("rst hold");
      chk("rst alusrcb", 8'(alusrcb), 8'd1);
      chk("rst state2", 8'(state2), 8'd0);
    end
    reset_n = 1'b1;
    #1;
    chk("post-rst irwrite", 8'(irwrite), 8'd1);
    chk("post-rst pcen", 8'(pcen), 8'd1);

    // lw: 0,1,2,3,4,0
    op = 6'b100011;
    chk("lw s0 alu", 8'(alucontrol), 8'd2);
    chk("lw s0 iord", 8'(iord), 8'd0);
    cyc();
    chk("lw s1", 8'(state), 8'd1);
    chk("lw s1 alu", 8'(alucontrol), 8'd2);
    chk("lw s1 alusrcb", 8'(alusrcb), 8'd3);
    chk_noen("lw s1");
    cyc();
    chk("lw s2", 8'(state), 8'd2);
    chk("lw s2 alu", 8'(alucontrol), 8'd2);
    chk("lw s2 alusrca", 8'(alusrca), 8'd1);
    chk("lw s2 alusrcb", 8'(alusrcb), 8'd2);
    chk("lw s2 iord", 8'(iord), 8'd0);
    cyc();
    chk("lw s3", 8'(state), 8'd3);
    chk("lw s3 iord", 8'(iord), 8'd1);
    chk("lw s3 regwrite", 8'(regwrite), 8'd0);
    cyc();
    chk("lw s4", 8'(state), 8'd4);
    chk("lw s4 regwrite", 8'(regwrite), 8'd1);
    chk("lw s4 memtoreg", 8'(memtoreg), 8'd1);
    chk("lw s4 regdst", 8'(regdst), 8'd0);
    chk("lw s4 iord", 8'(iord), 8'd0);
    cyc();
    chk("lw back", 8'(state), 8'd0);
    chk("lw back memtoreg", 8'(memtoreg), 8'd0);

    // sw: 0,1,2,5,0
    op = 6'b101011;
    cyc();
    chk("sw s1", 8'(state), 8'd1);
    chk("sw s1 memwrite", 8'(memwrite), 8'd0);
    cyc();
    chk("sw s2", 8'(state), 8'd2);
    chk("sw s2 memwrite", 8'(memwrite), 8'd0);
    cyc();
    chk("sw s5", 8'(state), 8'd5);
    chk("sw s5 memwrite", 8'(memwrite), 8'd1);
    chk("sw s5 iord", 8'(iord), 8'd1);
    chk("sw s5 regwrite", 8'(regwrite), 8'd0);
    cyc();
    chk("sw back", 8'(state), 8'd0);
    chk("sw back memwrite", 8'(memwrite), 8'd0);

    // R-type across the funct table
    op = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = fn_tab[i];
      cyc();
      chk("rt s1", 8'(state), 8'd1);
      chk("rt s1 alu", 8'(alucontrol), 8'd2);
      cyc();
      chk("rt s6", 8'(state), 8'd6);
      chk("rt s6 alu", 8'(alucontrol), 8'(alu_tab[i]));
      chk("rt s6 alusrca", 8'(alusrca), 8'd1);
      chk("rt s6 alusrcb", 8'(alusrcb), 8'd0);
      cyc();
      chk("rt s7", 8'(state), 8'd7);
      chk("rt s7 regwrite", 8'(regwrite), 8'd1);
      chk("rt s7 regdst", 8'(regdst), 8'd1);
      cyc();
      chk("rt back", 8'(state), 8'd0);
    end

    // beq taken then not taken
    op = 6'b000100;
    funct = 6'b000000;
    for (int t = 1; t >= 0; t--) begin
      zero = 1'b0;
      cyc();
      chk("beq s1", 8'(state), 8'd1);
      zero = (t == 1);
      cyc();
      chk("beq s8", 8'(state), 8'd8);
      chk("beq s8 alu", 8'(alucontrol), 8'd6);
      chk("beq s8 pcsrc", 8'(pcsrc), 8'd1);
      chk("beq s8 pcen", 8'(pcen), 8'(t));
      chk("beq s8 regwrite", 8'(regwrite), 8'd0);
      cyc();
      chk("beq back", 8'(state), 8'd0);
    end
    zero = 1'b0;

    // Unsupported op: 0,1,0
    op = 6'b111111;
    cyc();
    chk("nop s1", 8'(state), 8'd1);
    chk_noen("nop s1");
    cyc();
    chk("nop back", 8'(state), 8'd0);

    // addi: full instance 0,1,9,10,0; reduced instance 0,1,0,1,0
    op = 6'b001000;
    cyc();
    chk("addi s1", 8'(state), 8'd1);
    chk("addi2 s1", 8'(state2), 8'd1);
    cyc();
    chk("addi s9", 8'(state), 8'd9);
    chk("addi s9 alusrcb", 8'(alusrcb), 8'd2);
    chk("addi2 back", 8'(state2), 8'd0);
    cyc();
    chk("addi s10", 8'(state), 8'd10);
    chk("addi s10 regwrite", 8'(regwrite), 8'd1);
    chk("addi s10 regdst", 8'(regdst), 8'd0);
    chk("addi2 s1 again", 8'(state2), 8'd1);
    chk("addi2 s1 regwrite", 8'(regwrite2), 8'd0);
    cyc();
    chk("addi back", 8'(state), 8'd0);
    chk("addi2 back2", 8'(state2), 8'd0);

    // j: full instance 0,1,11,0; reduced instance falls back to FETCH
    op = 6'b000010;
    cyc();
    chk("j s1", 8'(state), 8'd1);
    cyc();
    chk("j s11", 8'(state), 8'd11);
    chk("j s11 pcsrc", 8'(pcsrc), 8'd2);
    chk("j s11 pcen", 8'(pcen), 8'd1);
    chk("j2 back", 8'(state2), 8'd0);
    cyc();
    chk("j back", 8'(state), 8'd0);

    // Asynchronous reset in the middle of MEMRD
    op = 6'b100011;
    cyc();
    cyc();
    cyc();
    chk("mid s3", 8'(state), 8'd3);
    reset_n = 1'b0;
    #1;
    chk("mid rst state", 8'(state), 8'd0);
    chk("mid rst iord", 8'(iord), 8'd0);
    chk_noen("mid rst");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mid hold state", 8'(state), 8'd0);
      chk("mid hold state2", 8'(state2), 8'd0);
      chk_noen("mid hold");
    end
    reset_n = 1'b1;
    #1;
    chk("mid post irwrite", 8'(irwrite), 8'd1);
    chk("mid post pcen", 8'(pcen), 8'd1);
    cyc();
    chk("mid post s1", 8'(state), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
